bombe_rotor_sequencer: RTL and testbench

Controller that sweeps a three-rotor bank (left, middle, right; positions 0–25 each) through all 17,576 settings for the bombe search. It loads a start setting, steps the bank in odometer order, waits a programmable settle time, and samples a hit line from the bombe test network. It sits between the user/top-level control logic and the three clocked rotors, and is the only block that drives their load and increment controls.

---
 rtl/bombe_pkg.sv | 45 ++++
 rtl/bombe_rotor_sequencer_odometer.sv | 59 +++++
 rtl/bombe_rotor_sequencer.sv | 169 ++++++++++++++++
 tb/tb_bombe_rotor_sequencer.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bombe_pkg.sv
// Shared constants, state encoding and position helpers for the bombe rotor sequencer.
// Consumers select stop-on-hit behaviour with the BOMBE_STOP_ON_HIT_EN macro.
package bombe_pkg;

  localparam int ROTOR_SIZE  = 26;
  localparam int ROTOR_MAX   = 25;
  localparam int SWEEP_TOTAL = 17576;
  localparam int POS_W       = 5;
  localparam int CNT_W       = 15;
  localparam int SETTLE_W    = 4;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_SETTLE = 3'd2;
  localparam logic [2:0] ST_CHECK  = 3'd3;
  localparam logic [2:0] ST_STEP   = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;
  localparam logic [2:0] ST_FOUND  = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_LOAD   = ST_LOAD,
    S_SETTLE = ST_SETTLE,
    S_CHECK  = ST_CHECK,
    S_STEP   = ST_STEP,
    S_DONE   = ST_DONE,
    S_FOUND  = ST_FOUND
  } state_t;

  // A 5-bit value never exceeds 31, so one conditional subtract is a full mod 26.
  function automatic logic [POS_W-1:0] reduce_mod26(input logic [POS_W-1:0] v);
    return (v > POS_W'(ROTOR_MAX)) ? v - POS_W'(ROTOR_SIZE) : v;
  endfunction

  // Out-of-range settle times are clamped into 1..15 rather than wrapping the counter.
  function automatic logic [SETTLE_W-1:0] settle_reload(input int cycles);
    if (cycles < 1)
      return '0;
    else if (cycles > 15)
      return SETTLE_W'(14);
    else
      return SETTLE_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/bombe_rotor_sequencer_odometer.sv
// Three mod-26 rotor position registers with odometer carry and registered per-rotor
// increment pulses; positions and pulses update on the same edge.
module rotor_odometer
  import bombe_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic             i_step,
  input  logic [POS_W-1:0] i_init_l,
  input  logic [POS_W-1:0] i_init_m,
  input  logic [POS_W-1:0] i_init_r,
  output logic [POS_W-1:0] o_pos_l,
  output logic [POS_W-1:0] o_pos_m,
  output logic [POS_W-1:0] o_pos_r,
  output logic [2:0]       o_inc
);

  localparam logic [POS_W-1:0] POS_MAX = POS_W'(ROTOR_MAX);

  logic [3*POS_W-1:0] w_init;
  logic [3*POS_W-1:0] w_pos;
  logic [2:0]         w_carry;
  logic [2:0]         w_adv;

  assign w_init = {i_init_l, i_init_m, i_init_r};

  // Carry is taken from the pre-increment positions of every faster rotor.
  assign w_adv = {i_step & w_carry[1] & w_carry[0], i_step & w_carry[0], i_step};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_rotor
      logic [POS_W-1:0] r_pos;
      logic             r_inc;

      assign w_carry[gi]              = (r_pos == POS_MAX);
      assign w_pos[gi*POS_W +: POS_W] = r_pos;
      assign o_inc[gi]                = r_inc;

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_pos <= '0;
          r_inc <= 1'b0;
        end else begin
          r_inc <= w_adv[gi] & ~i_load;
          if (i_load)
            r_pos <= w_init[gi*POS_W +: POS_W];
          else if (w_adv[gi])
            r_pos <= w_carry[gi] ? '0 : r_pos + 1'b1;
        end
      end
    end
  endgenerate

  assign o_pos_l = w_pos[2*POS_W +: POS_W];
  assign o_pos_m = w_pos[1*POS_W +: POS_W];
  assign o_pos_r = w_pos[0*POS_W +: POS_W];

endmodule

// File: rtl/bombe_rotor_sequencer.sv
// Sweeps a three-rotor bank through all 17,576 settings, settling and sampling hit on each.
// BOMBE_STOP_ON_HIT_EN: stop in FOUND on a hit; otherwise hits are tallied in o_hit_count.
module bombe_rotor_sequencer
  import bombe_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             i_clk,
  input  logic             i_resetn,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [POS_W-1:0] i_init_l,
  input  logic [POS_W-1:0] i_init_m,
  input  logic [POS_W-1:0] i_init_r,
  input  logic             i_hit,
  output logic [POS_W-1:0] o_pos_l,
  output logic [POS_W-1:0] o_pos_m,
  output logic [POS_W-1:0] o_pos_r,
  output logic             o_rotor_load,
  output logic [2:0]       o_rotor_inc,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_found,
  output logic [CNT_W-1:0] o_step_count
`ifndef BOMBE_STOP_ON_HIT_EN
  ,
  output logic [CNT_W-1:0] o_hit_count
`endif
);

  localparam logic [SETTLE_W-1:0] SETTLE_RELOAD = settle_reload(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0]    SWEEP_CNT     = CNT_W'(SWEEP_TOTAL);

  state_t              r_state;
  state_t              w_state_next;
  logic                w_launch;
  logic                w_step;
  logic                w_check;
  logic [SETTLE_W-1:0] r_settle_cnt;
  logic [CNT_W-1:0]    r_step_count;
  logic [CNT_W-1:0]    w_step_count_inc;
  logic                r_rotor_load;
  logic                r_done;
  logic [POS_W-1:0]    w_init_l;
  logic [POS_W-1:0]    w_init_m;
  logic [POS_W-1:0]    w_init_r;

  assign w_init_l = reduce_mod26(i_init_l);
  assign w_init_m = reduce_mod26(i_init_m);
  assign w_init_r = reduce_mod26(i_init_r);

  assign w_step_count_inc = (r_step_count == SWEEP_CNT) ? r_step_count : r_step_count + 1'b1;

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn)
      r_state <= S_IDLE;
    else
      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_launch     = 1'b0;
    w_step       = 1'b0;
    w_check      = 1'b0;
    case (r_state)
      S_IDLE, S_DONE, S_FOUND: begin
        if (i_start)
          w_state_next = S_LOAD;
      end
      S_LOAD: w_state_next = S_SETTLE;
      S_SETTLE: begin
        if (r_settle_cnt == '0)
          w_state_next = S_CHECK;
      end
      S_CHECK: begin
        if (w_step_count_inc == SWEEP_CNT)
          w_state_next = S_DONE;
        else
          w_state_next = S_STEP;
`ifdef BOMBE_STOP_ON_HIT_EN
        if (i_hit)
          w_state_next = S_FOUND;
`endif
      end
      S_STEP:  w_state_next = S_SETTLE;
      default: w_state_next = S_IDLE;
    endcase
    // Abort overrides every transition, including a start in the same cycle.
    if (i_abort)
      w_state_next = S_IDLE;
    w_launch = (w_state_next == S_LOAD);
    w_step   = (w_state_next == S_STEP);
    w_check  = (r_state == S_CHECK) && !i_abort;
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_rotor_load <= 1'b0;
      r_settle_cnt <= '0;
      r_step_count <= '0;
      r_done       <= 1'b0;
    end else begin
      r_rotor_load <= w_launch;
      if (r_state == S_LOAD || r_state == S_STEP)
        r_settle_cnt <= SETTLE_RELOAD;
      else if (r_state == S_SETTLE && r_settle_cnt != '0)
        r_settle_cnt <= r_settle_cnt - 1'b1;
      if (w_launch) begin
        r_step_count <= '0;
        r_done       <= 1'b0;
      end else begin
        if (w_check)
          r_step_count <= w_step_count_inc;
        if (w_state_next == S_DONE)
          r_done <= 1'b1;
      end
    end
  end

`ifdef BOMBE_STOP_ON_HIT_EN
  logic r_found;

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn)
      r_found <= 1'b0;
    else if (w_launch)
      r_found <= 1'b0;
    else if (w_state_next == S_FOUND)
      r_found <= 1'b1;
  end

  assign o_found = r_found;
`else
  logic [CNT_W-1:0] r_hit_count;

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn)
      r_hit_count <= '0;
    else if (w_launch)
      r_hit_count <= '0;
    else if (w_check && i_hit && r_hit_count != '1)
      r_hit_count <= r_hit_count + 1'b1;
  end

  assign o_found     = 1'b0;
  assign o_hit_count = r_hit_count;
`endif

  rotor_odometer u_odometer (
    .i_clk    (i_clk),
    .i_rst_n  (i_resetn),
    .i_load   (w_launch),
    .i_step   (w_step),
    .i_init_l (w_init_l),
    .i_init_m (w_init_m),
    .i_init_r (w_init_r),
    .o_pos_l  (o_pos_l),
    .o_pos_m  (o_pos_m),
    .o_pos_r  (o_pos_r),
    .o_inc    (o_rotor_inc)
  );

  assign o_rotor_load = r_rotor_load;
  assign o_step_count = r_step_count;
  assign o_done       = r_done;
  assign o_busy       = (r_state != S_IDLE) && (r_state != S_DONE) && (r_state != S_FOUND);

endmodule

// File: tb/tb_bombe_rotor_sequencer.sv
// Randomized self-checking bench for bombe_rotor_sequencer against a setting-index model.
// Honours BOMBE_STOP_ON_HIT_EN the same way as the design.
module tb_bombe_rotor_sequencer;

  localparam int SETTLE = 2;
  localparam int TOTAL  = 17576;
`ifdef BOMBE_STOP_ON_HIT_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        hit = 1'b0;
  logic [4:0]  init_l = '0, init_m = '0, init_r = '0;
  logic [4:0]  pos_l, pos_m, pos_r;
  logic        rotor_load;
  logic [2:0]  rotor_inc;
  logic        busy, done, found;
  logic [14:0] step_count;
`ifndef BOMBE_STOP_ON_HIT_EN
  logic [14:0] hit_count;
`endif

  int checks = 0;
  int errors = 0;
  int m_idx, m_steps, m_hits;

  always #5 clk = ~clk;

  bombe_rotor_sequencer #(.SETTLE_CYCLES(SETTLE)) dut (
    .i_clk        (clk),
    .i_resetn     (rst_n),
    .i_start      (start),
    .i_abort      (abort),
    .i_init_l     (init_l),
    .i_init_m     (init_m),
    .i_init_r     (init_r),
    .i_hit        (hit),
    .o_pos_l      (pos_l),
    .o_pos_m      (pos_m),
    .o_pos_r      (pos_r),
    .o_rotor_load (rotor_load),
    .o_rotor_inc  (rotor_inc),
    .o_busy       (busy),
    .o_done       (done),
    .o_found      (found),
    .o_step_count (step_count)
`ifndef BOMBE_STOP_ON_HIT_EN
    ,
    .o_hit_count  (hit_count)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Setting index -> {L,M,R} digits in base 26.
  function automatic logic [14:0] setting(input int idx);
    int l, m, r;
    l = idx / 676;
    m = (idx / 26) % 26;
    r = idx % 26;
    return {5'(l), 5'(m), 5'(r)};
  endfunction

  // Rotors that move are exactly the digits that differ between consecutive indices.
  function automatic logic [2:0] inc_mask(input int prev);
    logic [14:0] a, b;
    a = setting(prev);
    b = setting((prev + 1) % TOTAL);
    return {a[14:10] != b[14:10], a[9:5] != b[9:5], a[4:0] != b[4:0]};
  endfunction

  task automatic launch(input logic [4:0] l, input logic [4:0] m, input logic [4:0] r);
    init_l = l; init_m = m; init_r = r;
    start = 1'b1;
    tick();
    start = 1'b0;
    m_idx   = (int'(l) % 26) * 676 + (int'(m) % 26) * 26 + (int'(r) % 26);
    m_steps = 0;
    m_hits  = 0;
    checks++;
    if ({rotor_load, rotor_inc, busy, done, found, step_count} !== {1'b1, 3'b000, 1'b1, 1'b0, 1'b0, 15'd0}) begin
      errors++;
      $display("FAIL launch_ctrl load=%b inc=%b busy=%b done=%b found=%b cnt=%0d expected 1 000 1 0 0 0",
               rotor_load, rotor_inc, busy, done, found, step_count);
    end
    checks++;
    if ({pos_l, pos_m, pos_r} !== setting(m_idx)) begin
      errors++;
      $display("FAIL launch_pos got %0d/%0d/%0d expected %0d", pos_l, pos_m, pos_r, m_idx);
    end
  endtask

  // Called in a LOAD or STEP cycle; returns in the following STEP cycle.
  task automatic step_one(input bit h);
    int prev;
    tick();
    checks++;
    if ({rotor_load, rotor_inc} !== 4'b0000) begin
      errors++;
      $display("FAIL settle_pulses load=%b inc=%b expected 0 000", rotor_load, rotor_inc);
    end
    repeat (SETTLE) tick();
    hit = h;
    tick();
    hit = 1'b0;
    prev = m_idx;
    if (m_steps < TOTAL) m_steps++;
    if (h) m_hits++;
    m_idx = (m_idx + 1) % TOTAL;
    checks++;
    if (step_count !== 15'(m_steps)) begin
      errors++;
      $display("FAIL step_count got %0d expected %0d", step_count, m_steps);
    end
    checks++;
    if ({rotor_load, busy, rotor_inc} !== {1'b0, 1'b1, inc_mask(prev)}) begin
      errors++;
      $display("FAIL step_pulse load=%b busy=%b inc=%b expected 0 1 %b", rotor_load, busy, rotor_inc, inc_mask(prev));
    end
    checks++;
    if ({pos_l, pos_m, pos_r} !== setting(m_idx)) begin
      errors++;
      $display("FAIL step_pos got %0d/%0d/%0d expected index %0d", pos_l, pos_m, pos_r, m_idx);
    end
`ifndef BOMBE_STOP_ON_HIT_EN
    checks++;
    if (hit_count !== 15'(m_hits)) begin
      errors++;
      $display("FAIL hit_count got %0d expected %0d", hit_count, m_hits);
    end
`endif
  endtask

  task automatic do_abort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if ({busy, rotor_load, rotor_inc} !== 5'b00000) begin
      errors++;
      $display("FAIL abort_idle busy=%b load=%b inc=%b expected 0 0 000", busy, rotor_load, rotor_inc);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if ({pos_l, pos_m, pos_r, rotor_load, rotor_inc, busy, done, found, step_count} !== '0) begin
      errors++;
      $display("FAIL reset_state pos=%0d/%0d/%0d load=%b inc=%b busy=%b done=%b found=%b cnt=%0d expected all 0",
               pos_l, pos_m, pos_r, rotor_load, rotor_inc, busy, done, found, step_count);
    end
  endtask

  task automatic test_first_setting();
    launch(5'd0, 5'd0, 5'd0);
    tick();
    tick();
    tick();
    checks++;
    if ({busy, step_count} !== {1'b1, 15'd0}) begin
      errors++;
      $display("FAIL first_check_c4 busy=%b cnt=%0d expected 1 0", busy, step_count);
    end
    tick();
    checks++;
    if ({step_count, rotor_inc, pos_l, pos_m, pos_r} !== {15'd1, 3'b001, 5'd0, 5'd0, 5'd1}) begin
      errors++;
      $display("FAIL first_step_c5 cnt=%0d inc=%b pos=%0d/%0d/%0d expected 1 001 0/0/1",
               step_count, rotor_inc, pos_l, pos_m, pos_r);
    end
    do_abort();
  endtask

  task automatic test_carry();
    launch(5'd3, 5'd25, 5'd25);
    step_one(1'b0);
    checks++;
    if ({rotor_inc, pos_l, pos_m, pos_r} !== {3'b111, 5'd4, 5'd0, 5'd0}) begin
      errors++;
      $display("FAIL carry_all inc=%b pos=%0d/%0d/%0d expected 111 4/0/0", rotor_inc, pos_l, pos_m, pos_r);
    end
    do_abort();
    launch(5'd25, 5'd25, 5'd25);
    step_one(1'b0);
    step_one(1'b0);
    checks++;
    if ({step_count, pos_l, pos_m, pos_r} !== {15'd2, 5'd0, 5'd0, 5'd1}) begin
      errors++;
      $display("FAIL wrap_left cnt=%0d pos=%0d/%0d/%0d expected 2 0/0/1", step_count, pos_l, pos_m, pos_r);
    end
    do_abort();
  endtask

  task automatic test_random();
    int n;
    for (int run = 0; run < 5; run++) begin
      launch(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      n = $urandom_range(20, 60);
      for (int k = 0; k < n; k++) step_one(STOP ? 1'b0 : 1'($urandom_range(0, 1)));
      do_abort();
      checks++;
      if ({pos_l, pos_m, pos_r} !== setting(m_idx)) begin
        errors++;
        $display("FAIL abort_step_pos got %0d/%0d/%0d expected index %0d", pos_l, pos_m, pos_r, m_idx);
      end
    end
  endtask

  task automatic test_abort();
    launch(5'($urandom_range(0, 25)), 5'($urandom_range(0, 25)), 5'($urandom_range(0, 25)));
    for (int k = 0; k < 10; k++) step_one(1'b0);
    tick();
    do_abort();
    checks++;
    if ({step_count, pos_l, pos_m, pos_r} !== {15'd10, setting(m_idx)}) begin
      errors++;
      $display("FAIL abort_settle cnt=%0d pos=%0d/%0d/%0d expected 10 index %0d",
               step_count, pos_l, pos_m, pos_r, m_idx);
    end
    repeat (3) tick();
    checks++;
    if ({busy, step_count} !== {1'b0, 15'd10}) begin
      errors++;
      $display("FAIL idle_hold busy=%b cnt=%0d expected 0 10", busy, step_count);
    end
    launch(5'd30, 5'd0, 5'd0);
    checks++;
    if (pos_l !== 5'd4) begin
      errors++;
      $display("FAIL init_reduce pos_l=%0d expected 4", pos_l);
    end
    do_abort();
  endtask

  task automatic test_start_abort();
    logic [14:0] held;
    held = {pos_l, pos_m, pos_r};
    init_l = 5'd9; init_m = 5'd9; init_r = 5'd9;
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    checks++;
    if ({busy, rotor_load, pos_l, pos_m, pos_r} !== {1'b0, 1'b0, held}) begin
      errors++;
      $display("FAIL start_abort busy=%b load=%b pos=%0d/%0d/%0d expected 0 0 held",
               busy, rotor_load, pos_l, pos_m, pos_r);
    end
  endtask

  task automatic test_reset_mid();
    launch(5'd12, 5'd6, 5'd24);
    for (int k = 0; k < 3; k++) step_one(1'b0);
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({pos_l, pos_m, pos_r, rotor_load, rotor_inc, busy, done, found, step_count} !== '0) begin
      errors++;
      $display("FAIL async_reset pos=%0d/%0d/%0d load=%b inc=%b busy=%b cnt=%0d expected all 0",
               pos_l, pos_m, pos_r, rotor_load, rotor_inc, busy, step_count);
    end
    #1;
    rst_n = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle busy=%b expected 0", busy);
    end
  endtask

  task automatic test_hit_target();
    int target;
    target = 7 * 676 + 12 * 26 + 3;
    launch(5'd7, 5'd11, 5'd23);
    for (int k = 0; k < 6; k++) step_one(1'b0);
    if (STOP) begin
      repeat (SETTLE + 1) tick();
      hit = 1'b1;
      tick();
      hit = 1'b0;
      checks++;
      if ({found, done, busy, step_count, pos_l, pos_m, pos_r} !== {3'b100, 15'd7, setting(target)}) begin
        errors++;
        $display("FAIL found_stop found=%b done=%b busy=%b cnt=%0d pos=%0d/%0d/%0d expected 1 0 0 7 7/12/3",
                 found, done, busy, step_count, pos_l, pos_m, pos_r);
      end
      repeat (4) tick();
      checks++;
      if ({found, rotor_inc, pos_l, pos_m, pos_r} !== {1'b1, 3'b000, setting(target)}) begin
        errors++;
        $display("FAIL found_hold found=%b inc=%b pos=%0d/%0d/%0d expected 1 000 7/12/3",
                 found, rotor_inc, pos_l, pos_m, pos_r);
      end
    end else begin
      step_one(m_idx == target);
      checks++;
      if ({found, busy, step_count} !== {1'b0, 1'b1, 15'd7}) begin
        errors++;
        $display("FAIL hit_continue found=%b busy=%b cnt=%0d expected 0 1 7", found, busy, step_count);
      end
    end
    do_abort();
  endtask

  task automatic test_full_sweep();
    int n, first;
    launch(5'($urandom_range(0, 25)), 5'($urandom_range(0, 25)), 5'($urandom_range(0, 25)));
    first = m_idx;
    n = 0;
    while (done !== 1'b1 && n < TOTAL * (SETTLE + 2) + 20) begin
      tick();
      n++;
    end
    checks++;
    if (n !== TOTAL * (SETTLE + 2)) begin
      errors++;
      $display("FAIL sweep_cycles got %0d expected %0d", n, TOTAL * (SETTLE + 2));
    end
    checks++;
    if ({done, busy, found, rotor_inc, step_count} !== {3'b100, 3'b000, 15'd17576}) begin
      errors++;
      $display("FAIL sweep_done done=%b busy=%b found=%b inc=%b cnt=%0d expected 1 0 0 000 17576",
               done, busy, found, rotor_inc, step_count);
    end
    checks++;
    if ({pos_l, pos_m, pos_r} !== setting((first + TOTAL - 1) % TOTAL)) begin
      errors++;
      $display("FAIL sweep_last_pos got %0d/%0d/%0d expected index %0d",
               pos_l, pos_m, pos_r, (first + TOTAL - 1) % TOTAL);
    end
`ifndef BOMBE_STOP_ON_HIT_EN
    checks++;
    if (hit_count !== 15'd0) begin
      errors++;
      $display("FAIL sweep_hits got %0d expected 0", hit_count);
    end
`endif
    repeat (5) tick();
    checks++;
    if ({done, step_count} !== {1'b1, 15'd17576}) begin
      errors++;
      $display("FAIL sweep_saturate done=%b cnt=%0d expected 1 17576", done, step_count);
    end
    launch(5'd1, 5'd2, 5'd3);
    step_one(1'b0);
    do_abort();
  endtask

  initial begin
    test_reset();
    test_first_setting();
    test_carry();
    test_random();
    test_abort();
    test_start_abort();
    test_reset_mid();
    test_hit_target();
    test_full_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
